decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 198 +++++++++++++++++++
 tb/tb_decode.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// RV32I decode stage: classifies the fetched instruction, forms its immediate and
// register operands, and holds it back while a source register has a write in flight.
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_exception,
    input  logic        in_exception_valid,
    output logic        stall_out,
    input  logic        flush,
    input  logic        ex_stall,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [3:0]  out_class,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic [3:0]  out_exception,
    output logic        out_exception_valid
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] CLS_LUI     = 4'd0;
    localparam logic [3:0] CLS_AUIPC   = 4'd1;
    localparam logic [3:0] CLS_JAL     = 4'd2;
    localparam logic [3:0] CLS_JALR    = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_LOAD    = 4'd5;
    localparam logic [3:0] CLS_STORE   = 4'd6;
    localparam logic [3:0] CLS_OPIMM   = 4'd7;
    localparam logic [3:0] CLS_OP      = 4'd8;
    localparam logic [3:0] CLS_FENCE   = 4'd9;
    localparam logic [3:0] CLS_SYSTEM  = 4'd10;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    localparam logic [3:0] EXC_ILLEGAL = 4'd2;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [3:0]  class_s;
    logic [31:0] imm_s;
    logic        illegal_s;
    logic        uses_rs1_s;
    logic        uses_rs2_s;
    logic        writes_rd_s;
    logic        exc_valid_s;
    logic [3:0]  exc_code_s;
    logic        rd_we_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] busy_r;
    logic [31:0] busy_eff_s;
    logic [31:0] clr_mask_s;
    logic [31:0] set_mask_s;
    logic [31:0] busy_next_s;
    logic        hazard_s;
    logic        accept_s;

    assign opcode_s    = in_instr[6:0];
    assign rd_s        = in_instr[11:7];
    assign rs1_s       = in_instr[19:15];
    assign rs2_s       = in_instr[24:20];
    assign rf_rs1_addr = rs1_s;
    assign rf_rs2_addr = rs2_s;

    assign imm_i_s = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u_s = {in_instr[31:12], 12'd0};
    assign imm_j_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Opcode classification: class, immediate format and register usage.
    always_comb begin
        class_s     = CLS_ILLEGAL;
        imm_s       = 32'd0;
        illegal_s   = 1'b0;
        uses_rs1_s  = 1'b0;
        uses_rs2_s  = 1'b0;
        writes_rd_s = 1'b0;
        case (opcode_s)
            OPC_LUI:    begin class_s = CLS_LUI;    imm_s = imm_u_s; writes_rd_s = 1'b1; end
            OPC_AUIPC:  begin class_s = CLS_AUIPC;  imm_s = imm_u_s; writes_rd_s = 1'b1; end
            OPC_JAL:    begin class_s = CLS_JAL;    imm_s = imm_j_s; writes_rd_s = 1'b1; end
            OPC_JALR:   begin class_s = CLS_JALR;   imm_s = imm_i_s; writes_rd_s = 1'b1; uses_rs1_s = 1'b1; end
            OPC_BRANCH: begin class_s = CLS_BRANCH; imm_s = imm_b_s; uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_LOAD:   begin class_s = CLS_LOAD;   imm_s = imm_i_s; writes_rd_s = 1'b1; uses_rs1_s = 1'b1; end
            OPC_STORE:  begin class_s = CLS_STORE;  imm_s = imm_s_s; uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_OPIMM:  begin class_s = CLS_OPIMM;  imm_s = imm_i_s; writes_rd_s = 1'b1; uses_rs1_s = 1'b1; end
            OPC_OP:     begin class_s = CLS_OP;     writes_rd_s = 1'b1; uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; end
            OPC_FENCE:  begin class_s = CLS_FENCE; end
            OPC_SYSTEM: begin class_s = CLS_SYSTEM; imm_s = imm_i_s; end
            default:    begin illegal_s = 1'b1; end
        endcase
    end

    // Fetch-raised exceptions take precedence over the illegal-opcode check.
    always_comb begin
        exc_valid_s = 1'b0;
        exc_code_s  = 4'd0;
        if (in_exception_valid) begin
            exc_valid_s = 1'b1;
            exc_code_s  = in_exception;
        end else if (illegal_s) begin
            exc_valid_s = 1'b1;
            exc_code_s  = EXC_ILLEGAL;
        end else begin
            exc_valid_s = 1'b0;
            exc_code_s  = 4'd0;
        end
    end

    assign rd_we_s   = writes_rd_s & (rd_s != 5'd0) & ~exc_valid_s;
    assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : rf_rs1_data;
    assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : rf_rs2_data;

    // A write-back in this cycle already unblocks its register (bypass).
    assign clr_mask_s = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign busy_eff_s = busy_r & ~clr_mask_s;
    assign hazard_s   = in_valid & ~in_exception_valid &
                        ((uses_rs1_s & busy_eff_s[rs1_s]) | (uses_rs2_s & busy_eff_s[rs2_s]));
    assign accept_s   = in_valid & ~flush & ~hazard_s & ~ex_stall;
    assign stall_out  = ~reset & in_valid & ~flush & (hazard_s | ex_stall);

    // Set after clear so a same-cycle issue to the written-back register keeps it busy.
    assign set_mask_s  = (accept_s & rd_we_s) ? (32'd1 << rd_s) : 32'd0;
    assign busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

    // Scoreboard of registers with an outstanding write.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Output pipeline register: flush squashes, ex_stall holds, accept loads, else bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid           <= 1'b0;
            out_pc              <= 32'd0;
            out_class           <= 4'd0;
            out_funct3          <= 3'd0;
            out_funct7b5        <= 1'b0;
            out_rs1_val         <= 32'd0;
            out_rs2_val         <= 32'd0;
            out_imm             <= 32'd0;
            out_rd              <= 5'd0;
            out_rd_we           <= 1'b0;
            out_exception       <= 4'd0;
            out_exception_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid           <= 1'b1;
            out_pc              <= in_pc;
            out_class           <= class_s;
            out_funct3          <= in_instr[14:12];
            out_funct7b5        <= in_instr[30];
            out_rs1_val         <= rs1_val_s;
            out_rs2_val         <= rs2_val_s;
            out_imm             <= imm_s;
            out_rd              <= rd_s;
            out_rd_we           <= rd_we_s;
            out_exception       <= exc_code_s;
            out_exception_valid <= exc_valid_s;
        end else if (!ex_stall) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: expected decode results are queued when an instruction
// is presented and compared when the stage registers its output.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_exception_valid, flush, ex_stall, wb_valid;
    logic [31:0] in_instr, in_pc, rf_rs1_data, rf_rs2_data;
    logic [3:0]  in_exception;
    logic [4:0]  wb_rd, rf_rs1_addr, rf_rs2_addr;
    logic        stall_out, out_valid, out_funct7b5, out_rd_we, out_exception_valid;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [3:0]  out_class, out_exception;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  exc;
        logic        excv;
        logic        full;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;

    always #5 clk = ~clk;

    // Register file stand-in: each register reads back a recognisable pattern.
    assign rf_rs1_data = 32'h1000_0000 | {27'd0, rf_rs1_addr};
    assign rf_rs2_data = 32'h1000_0000 | {27'd0, rf_rs2_addr};

    decode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_exception(in_exception), .in_exception_valid(in_exception_valid),
        .stall_out(stall_out), .flush(flush), .ex_stall(ex_stall),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_pc(out_pc), .out_class(out_class),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_exception(out_exception), .out_exception_valid(out_exception_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] cls, input logic [2:0] f3,
                                input logic f7, input logic [31:0] rs1v, input logic [31:0] rs2v,
                                input logic [31:0] imm, input logic [4:0] rd, input logic we,
                                input logic [3:0] exc, input logic excv, input logic full);
        exp_t e;
        e.pc = pc; e.cls = cls; e.f3 = f3; e.f7 = f7; e.rs1v = rs1v; e.rs2v = rs2v;
        e.imm = imm; e.rd = rd; e.we = we; e.exc = exc; e.excv = excv; e.full = full;
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".pc"}, out_pc, e.pc);
        if (e.full) begin
            check({tag, ".class"}, out_class, e.cls);
            check({tag, ".imm"}, out_imm, e.imm);
        end
        check({tag, ".funct3"}, out_funct3, e.f3);
        check({tag, ".funct7b5"}, out_funct7b5, e.f7);
        check({tag, ".rs1_val"}, out_rs1_val, e.rs1v);
        check({tag, ".rs2_val"}, out_rs2_val, e.rs2v);
        check({tag, ".rd"}, out_rd, e.rd);
        check({tag, ".rd_we"}, out_rd_we, e.we);
        check({tag, ".exc"}, out_exception, e.exc);
        check({tag, ".exc_valid"}, out_exception_valid, e.excv);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            last_e = exp_q.pop_front();
            check_out(tag, last_e);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic exv, input logic [3:0] exc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        in_exception_valid = exv; in_exception = exc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_stall = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
        drive(32'h0050_0093, 32'h0, 1'b0, 4'd0);
        #1 check("rst_stall_low", stall_out, 1'b0);
        step(); step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_imm", out_imm, 32'd0);
        check("rst_rd_we", out_rd_we, 1'b0);
        check("rst_excv", out_exception_valid, 1'b0);
        check("rst_stall_low2", stall_out, 1'b0);

        // ADDI x1,x0,5
        reset = 1'b0; ex_stall = 1'b0;
        drive(32'h0050_0093, 32'h0, 1'b0, 4'd0);
        #1;
        check("addi_rs1_addr", rf_rs1_addr, 5'd0);
        check("addi_rs2_addr", rf_rs2_addr, 5'd5);
        check("addi_stall", stall_out, 1'b0);
        exp_q.push_back(mk(32'h0, 4'd7, 3'd0, 1'b0, 32'd0, 32'h1000_0005, 32'd5, 5'd1, 1'b1, 4'd0, 1'b0, 1'b1));
        step(); pop_check("addi");

        // ADD x2,x1,x1 waits for x1, then issues in the write-back cycle
        drive(32'h0010_8133, 32'h4, 1'b0, 4'd0);
        #1 check("add_stall1", stall_out, 1'b1);
        step(); check("add_bubble1", out_valid, 1'b0);
        check("add_stall2", stall_out, 1'b1);
        step(); check("add_bubble2", out_valid, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1 check("add_wb_bypass", stall_out, 1'b0);
        exp_q.push_back(mk(32'h4, 4'd8, 3'd0, 1'b0, 32'h1000_0001, 32'h1000_0001, 32'd0, 5'd2, 1'b1, 4'd0, 1'b0, 1'b1));
        step(); wb_valid = 1'b0; pop_check("add");

        // Illegal opcode
        drive(32'hFFFF_FFFF, 32'h8, 1'b0, 4'd0);
        #1 check("ill_stall", stall_out, 1'b0);
        exp_q.push_back(mk(32'h8, 4'd0, 3'd7, 1'b1, 32'h1000_001F, 32'h1000_001F, 32'd0, 5'd31, 1'b0, 4'd2, 1'b1, 1'b0));
        step(); pop_check("illegal");

        // Fetch exception on ADD x3,x2,x2 while x2 busy: no hazard, no scoreboard set
        drive(32'h0021_01B3, 32'h2, 1'b1, 4'd0);
        #1 check("fexc_stall", stall_out, 1'b0);
        exp_q.push_back(mk(32'h2, 4'd8, 3'd0, 1'b0, 32'h1000_0002, 32'h1000_0002, 32'd0, 5'd3, 1'b0, 4'd0, 1'b1, 1'b1));
        step(); pop_check("fetch_exc");

        // ADDI x4,x3,0: x3 must not have been marked busy
        drive(32'h0001_8213, 32'hC, 1'b0, 4'd0);
        #1 check("x3_free_stall", stall_out, 1'b0);
        exp_q.push_back(mk(32'hC, 4'd7, 3'd0, 1'b0, 32'h1000_0003, 32'd0, 32'd0, 5'd4, 1'b1, 4'd0, 1'b0, 1'b1));
        step(); pop_check("addi_x3");

        // BEQ x0,x0,-4
        drive(32'hFE00_0EE3, 32'h10, 1'b0, 4'd0);
        exp_q.push_back(mk(32'h10, 4'd4, 3'd0, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFC, 5'd29, 1'b0, 4'd0, 1'b0, 1'b1));
        step(); pop_check("beq");

        // LUI x5,0x12345
        drive(32'h1234_52B7, 32'h14, 1'b0, 4'd0);
        exp_q.push_back(mk(32'h14, 4'd0, 3'd5, 1'b0, 32'h1000_0008, 32'h1000_0003, 32'h1234_5000, 5'd5, 1'b1, 4'd0, 1'b0, 1'b1));
        step(); pop_check("lui");

        // Downstream stall holds the LUI result; flush during the stall squashes
        drive(32'h0000_1317, 32'h18, 1'b0, 4'd0);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("exst_stall", stall_out, 1'b1);
            step(); check_out("exst_hold", last_e);
        end
        flush = 1'b1;
        #1 check("flush_stall", stall_out, 1'b0);
        step(); check("flush_valid", out_valid, 1'b0);
        flush = 1'b0; ex_stall = 1'b0;
        exp_q.push_back(mk(32'h18, 4'd1, 3'd1, 1'b0, 32'd0, 32'd0, 32'h0000_1000, 5'd6, 1'b1, 4'd0, 1'b0, 1'b1));
        step(); pop_check("auipc");

        // ADD x7,x5,x5 stalls on x5; reset clears the scoreboard and the pending instruction
        drive(32'h0052_83B3, 32'h1C, 1'b0, 4'd0);
        #1 check("x5_stall", stall_out, 1'b1);
        step(); check("x5_bubble", out_valid, 1'b0);
        reset = 1'b1;
        #1 check("rst_mid_stall", stall_out, 1'b0);
        step();
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_pc", out_pc, 32'd0);
        reset = 1'b0;
        #1 check("post_rst_stall", stall_out, 1'b0);
        exp_q.push_back(mk(32'h1C, 4'd8, 3'd0, 1'b0, 32'h1000_0005, 32'h1000_0005, 32'd0, 5'd7, 1'b1, 4'd0, 1'b0, 1'b1));
        step(); pop_check("add_post_rst");

        in_valid = 1'b0;
        step();
        check("idle_bubble", out_valid, 1'b0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
